// File: rtl/regfile_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Shared types and default sizes for the multi-port register file
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    typedef enum logic [0:0] {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_t;

    localparam int RF_XLEN  = 32;
    localparam int RF_NREGS = 32;

endpackage

`default_nettype wire

// File: rtl/regfile_mp_if.sv
// ============================================================================
// Module      : regfile_mp_if
// Description : Read/write port bundle between the core and the register file
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int XLEN  = RF_XLEN,
    parameter int NREGS = RF_NREGS,
    parameter int NRD   = 2
) ();
    localparam int AW = $clog2(NREGS);

    logic                 ready;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*XLEN-1:0]  rd_data;
    logic                 we0;
    logic [AW-1:0]        wa0;
    logic [XLEN-1:0]      wd0;
    logic                 we1;
    logic [AW-1:0]        wa1;
    logic [XLEN-1:0]      wd1;

    modport master (
        input  ready, rd_data,
        output rd_addr, we0, wa0, wd0, we1, wa1, wd1
    );

    modport slave (
        output ready, rd_data,
        input  rd_addr, we0, wa0, wd0, we1, wa1, wd1
    );

endinterface

`default_nettype wire

// File: rtl/regfile_clear_seq.sv
// ============================================================================
// Module      : regfile_clear_seq
// Description : Post-reset sweep that zeroes every entry before raising ready
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int NREGS = RF_NREGS,
    parameter int AW    = $clog2(NREGS)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    output logic               o_ready,
    output logic               o_clr_we,
    output logic [AW-1:0]      o_clr_addr
);

    localparam logic [AW-1:0] c_LAST = AW'(NREGS - 1);

    rf_state_t     r_state;
    logic [AW-1:0] r_cnt;
    logic          r_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RF_CLEAR;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else if (r_state == RF_CLEAR) begin
            r_cnt <= r_cnt + AW'(1);
            if (r_cnt == c_LAST) begin
                r_state <= RF_RUN;
                r_ready <= 1'b1;
            end
        end
    end

    // No clear write on a reset edge: the sweep restarts from entry 0 next cycle.
    assign o_clr_we   = (r_state == RF_CLEAR) && !rst;
    assign o_clr_addr = r_cnt;
    assign o_ready    = r_ready;

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// Module      : regfile_mp
// Description : Dual-write, NRD-read register file with bypass and clear sweep
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = RF_XLEN,
    parameter int NREGS    = RF_NREGS,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  wire logic     clk,
    input  wire logic     rst,
    regfile_mp_if.slave   bus
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]     r_mem [NREGS];
    logic                w_run;
    logic                w_clr_we;
    logic [AW-1:0]       w_clr_addr;
    logic                w_we0;
    logic                w_we1;
    logic [NRD*XLEN-1:0] w_rd_data;

    regfile_clear_seq #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_clear_seq (
        .clk        (clk),
        .rst        (rst),
        .o_ready    (w_run),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );

    assign w_we0 = bus.we0 && w_run && !((ZERO_REG != 0) && (bus.wa0 == '0));
    assign w_we1 = bus.we1 && w_run && !((ZERO_REG != 0) && (bus.wa1 == '0));

    // Port 1 is assigned last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else begin
            if (w_we0) r_mem[bus.wa0] <= bus.wd0;
            if (w_we1) r_mem[bus.wa1] <= bus.wd1;
        end
    end

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [AW-1:0]   w_ra;
        logic [XLEN-1:0] w_rdv;

        assign w_ra = bus.rd_addr[gi*AW +: AW];

        always_comb begin
            w_rdv = r_mem[w_ra];
            if (BYPASS != 0) begin
                if (w_we1 && (bus.wa1 == w_ra))      w_rdv = bus.wd1;
                else if (w_we0 && (bus.wa0 == w_ra)) w_rdv = bus.wd0;
            end
            if (!w_run || ((ZERO_REG != 0) && (w_ra == '0))) w_rdv = '0;
        end

        assign w_rd_data[gi*XLEN +: XLEN] = w_rdv;
    end

    assign bus.rd_data = w_rd_data;
    assign bus.ready   = w_run;

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
// Module      : tb_regfile_mp
// Description : Checks two register files (bypass on/off) against a simple model
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_mp;

    localparam int c_XLEN  = 32;
    localparam int c_NREGS = 32;
    localparam int c_NRD   = 2;
    localparam int c_AW    = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic chk_en   = 1'b0;

    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(c_XLEN), .NREGS(c_NREGS), .NRD(c_NRD)) bus_b ();
    regfile_mp_if #(.XLEN(c_XLEN), .NREGS(c_NREGS), .NRD(c_NRD)) bus_n ();

    regfile_mp #(.XLEN(c_XLEN), .NREGS(c_NREGS), .NRD(c_NRD), .ZERO_REG(1), .BYPASS(1))
        u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    regfile_mp #(.XLEN(c_XLEN), .NREGS(c_NREGS), .NRD(c_NRD), .ZERO_REG(1), .BYPASS(0))
        u_dut_n (.clk(clk), .rst(rst), .bus(bus_n));

    // Reference: contents array plus a countdown of sweep cycles remaining.
    logic [31:0] m_mem [c_NREGS];
    logic        m_ready = 1'b0;
    int          m_left  = c_NREGS;

    logic        s_we0, s_we1;
    logic [4:0]  s_wa0, s_wa1, s_ra0, s_ra1;
    logic [31:0] s_wd0, s_wd1;

    always @(posedge clk) begin
        if (rst) begin
            m_ready <= 1'b0;
            m_left  <= c_NREGS;
            for (int k = 0; k < c_NREGS; k++) m_mem[k] <= 32'h0;
        end else if (!m_ready) begin
            m_left <= m_left - 1;
            if (m_left == 1) m_ready <= 1'b1;
        end else begin
            if (s_we0 && s_wa0 != 0) m_mem[s_wa0] <= s_wd0;
            if (s_we1 && s_wa1 != 0) m_mem[s_wa1] <= s_wd1;
        end
    end

    function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] a);
        if (!m_ready || a == 0) return 32'h0;
        if (byp && s_we1 && s_wa1 == a) return s_wd1;
        if (byp && s_we0 && s_wa0 == a) return s_wd0;
        return m_mem[a];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready_b", {31'b0, bus_b.ready}, {31'b0, m_ready});
            check("ready_n", {31'b0, bus_n.ready}, {31'b0, m_ready});
            check("rd0_b", bus_b.rd_data[31:0],  exp_rd(1'b1, s_ra0));
            check("rd1_b", bus_b.rd_data[63:32], exp_rd(1'b1, s_ra1));
            check("rd0_n", bus_n.rd_data[31:0],  exp_rd(1'b0, s_ra0));
            check("rd1_n", bus_n.rd_data[63:32], exp_rd(1'b0, s_ra1));
        end
    end

    task automatic drive(input logic we0, input logic [4:0] wa0, input logic [31:0] wd0,
                         input logic we1, input logic [4:0] wa1, input logic [31:0] wd1,
                         input logic [4:0] ra0, input logic [4:0] ra1);
        s_we0 = we0; s_wa0 = wa0; s_wd0 = wd0;
        s_we1 = we1; s_wa1 = wa1; s_wd1 = wd1;
        s_ra0 = ra0; s_ra1 = ra1;
        bus_b.we0 = we0; bus_b.wa0 = wa0; bus_b.wd0 = wd0;
        bus_b.we1 = we1; bus_b.wa1 = wa1; bus_b.wd1 = wd1;
        bus_b.rd_addr = {ra1, ra0};
        bus_n.we0 = we0; bus_n.wa0 = wa0; bus_n.wd0 = wd0;
        bus_n.we1 = we1; bus_n.wa1 = wa1; bus_n.wd1 = wd1;
        bus_n.rd_addr = {ra1, ra0};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    endtask

    // Counts edges after release until ready; optional reset at a given sweep cycle.
    task automatic sweep(input int reset_at, output int edges);
        edges = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (n == 10) drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
            else idle();
            if (n == reset_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                n = 0;
                reset_at = -1;
                continue;
            end
            if (bus_b.ready) begin
                edges = n;
                break;
            end
        end
    endtask

    initial begin
        int edges;
        idle();
        rst = 1'b1;
        repeat (3) tick();
        chk_en = 1'b1;
        check("reset_ready", {31'b0, bus_b.ready}, 32'h0);
        check("reset_rd", bus_b.rd_data[31:0], 32'h0);
        rst = 1'b0;
        sweep(-1, edges);
        check("ready_latency", edges, 32'd32);

        for (int a = 0; a < c_NREGS; a += 2) begin
            drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'(a), 5'(a + 1));
            #1;
            check("cleared_even", bus_b.rd_data[31:0], 32'h0);
            check("cleared_odd", bus_b.rd_data[63:32], 32'h0);
            tick();
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        #1;
        check("x5_dropped", bus_n.rd_data[31:0], 32'h0);

        // Basic write then read.
        tick();
        drive(1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 32'h0, 5'd1, 5'd1);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0);
        #1;
        check("x7_read", bus_n.rd_data[31:0], 32'h12345678);
        check("x0_read", bus_n.rd_data[63:32], 32'h0);

        // Collision and dual write to different registers.
        tick();
        drive(1'b1, 5'd3, 32'hAAAA0000, 1'b1, 5'd3, 32'h0000BBBB, 5'd3, 5'd3);
        #1;
        check("coll_bypass", bus_b.rd_data[31:0], 32'h0000BBBB);
        tick();
        drive(1'b1, 5'd4, 32'h44444444, 1'b1, 5'd9, 32'h99999999, 5'd3, 5'd4);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd9);
        #1;
        check("x3_coll", bus_n.rd_data[31:0], 32'h0000BBBB);
        check("x9_dual", bus_n.rd_data[63:32], 32'h99999999);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd4, 5'd4);
        #1;
        check("x4_dual", bus_n.rd_data[31:0], 32'h44444444);

        // Bypass on vs off.
        tick();
        drive(1'b1, 5'd2, 32'h11, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        tick();
        drive(1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 32'h0, 5'd2, 5'd2);
        #1;
        check("bypass_on", bus_b.rd_data[31:0], 32'h22);
        check("bypass_off", bus_n.rd_data[31:0], 32'h11);

        // Zero register.
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        #1;
        check("x0_bypass", bus_b.rd_data[31:0], 32'h0);
        tick();
        idle();
        #1;
        check("x0_after", bus_b.rd_data[63:32], 32'h0);

        // Randomized traffic; small address window sometimes to force collisions.
        for (int n = 0; n < 2000; n++) begin
            int mask;
            tick();
            mask = ($urandom_range(0, 3) == 0) ? 3 : 31;
            drive(1'($urandom), 5'($urandom & mask), $urandom,
                  1'($urandom), 5'($urandom & mask), $urandom,
                  5'($urandom & mask), 5'($urandom & mask));
        end

        // Mid-sweep reset.
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sweep(15, edges);
        check("midsweep_latency", edges, 32'd32);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd3);
        #1;
        check("midsweep_x7", bus_b.rd_data[31:0], 32'h0);
        repeat (2) tick();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file: the successor to the single-write, dual-read 32×32 bank in the single-cycle core. It adds configurable width, depth and read-port count; a second write port for a separate load/writeback path; same-cycle write-to-read bypass; and a hardware clear sweep after reset. It sits in the decode/writeback stage and feeds the ALU operand muxes.

## Interface
- `XLEN`, default 32: register width in bits.
- `NREGS`, default 32: number of registers, ≥2, power of two. `AW = $clog2(NREGS)`.
- `NRD`, default 2: number of read ports, 1..4.
- `ZERO_REG`, default 1: when 1, register 0 reads 0 and ignores writes.
- `BYPASS`, default 1: when 1, same-cycle writes are forwarded to reads.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `ready`  out  1: high when the clear sweep is complete and the file is usable.
- `rd_addr`  in  NRD*AW: read addresses. Port i uses bits `[i*AW +: AW]`.
- `rd_data`  out  NRD*XLEN: read data. Port i uses bits `[i*XLEN +: XLEN]`. Combinational.
- `we0`, `wa0` (AW), `wd0` (XLEN)  in: write port 0 (ALU writeback).
- `we1`, `wa1` (AW), `wd1` (XLEN)  in: write port 1 (load writeback).

## Operation
- Clear sweep, with states CLEAR and RUN.
  - `rst` high: state becomes CLEAR, `cnt` becomes 0, `ready` becomes 0.
  - In CLEAR with `rst` low: each cycle writes 0 to entry `cnt` and increments `cnt`.
  - When `cnt == NREGS-1`, the next state is RUN and `ready` becomes 1.
  - `rst` asserted mid-sweep restarts the sweep from 0.
- Behaviour in CLEAR:
  - Both write ports are ignored.
  - All `rd_data` read 0.
- Writes in RUN are applied on the rising edge.
  - A write with `weN` high is ignored if `waN == 0` and `ZERO_REG == 1`.
  - If both ports write the same address in one cycle, port 1 wins.
  - Writes to different addresses both commit.
- Reads in RUN return the entry's value for each port i.
  - Register 0 returns 0 when `ZERO_REG == 1`.
  - With `BYPASS == 1`, if a valid write targets `rd_addr[i]` in the same cycle, the read returns that write data instead. If both ports hit, `wd1` is returned.
  - With `BYPASS == 0`, reads return the pre-edge contents.
- Out-of-range addresses cannot occur, because `NREGS` is a power of two.

## Timing
- Reset values:
  - `ready` = 0.
  - `rd_data` = 0 throughout CLEAR.
  - All entries are 0 once `ready` rises.
- `ready` rises exactly `NREGS` cycles after the first edge with `rst` low (32 for the defaults).
- Write latency is 1 edge.
- Read latency is 0 cycles (combinational). With bypass, write data is visible in the same cycle.
- No handshake on read or write ports. Upstream must hold off writes until `ready` is high; writes before then are dropped.

## Structure
- The package `regfile_pkg` holds:
  - the state enum `rf_state_t {RF_CLEAR, RF_RUN}`;
  - the default constants `RF_XLEN = 32` and `RF_NREGS = 32`.
- One sub-module, `regfile_clear_seq`. It holds the state, `cnt`, `ready`, and produces the clear write-enable and clear address.
- The top level muxes the clear write path against ports 0 and 1, and handles bypass and zero-register read logic in a generate loop over `NRD`.

## Test plan
- Reset sweep: hold `rst` 3 cycles, then release.
  - `ready` = 0 for exactly 32 cycles, then 1.
  - All 32 registers read 0.
  - A write of `0xDEADBEEF` to x5 issued at cycle 10 is dropped; x5 still reads 0.
- Basic write/read: `we0`, x7 ← `0x12345678`. Next cycle, `rd_addr0` = 7 gives `0x12345678`, and `rd_addr1` = 0 gives 0.
- Dual-write collision: in one cycle, `we0` x3 ← `0xAAAA0000` and `we1` x3 ← `0x0000BBBB`. x3 reads `0x0000BBBB` afterwards. A separate dual write to x4/x9 commits both values.
- Bypass, with x2 holding `0x11`: write x2 ← `0x22` and read x2 in the same cycle.
  - `BYPASS = 1` returns `0x22`.
  - `BYPASS = 0` returns `0x11`.
- Zero register: `we1` x0 ← `0xFFFFFFFF`. x0 reads 0, including the same-cycle bypass read.
- Mid-sweep reset: assert `rst` at sweep cycle 15. `ready` rises 32 cycles after the second release, not earlier.
